uart_rx_controller: RTL and testbench

//   Serial front end of the UART receive path: synchronises RxD, detects start bit, oversamples

---
 rtl/uart_rx_controller_pkg.sv | 14 +
 rtl/uart_rx_controller_if.sv | 25 ++
 rtl/uart_rx_controller_baud_tick.sv | 30 +++
 rtl/uart_rx_controller.sv | 136 +++++++++++++
 tb/tb_uart_rx_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_controller_pkg.sv
// Shared UART receive-path types and constants.
// Frame: 1 start bit, UART_WORD_SIZE data bits LSB first, 1 stop bit, no parity.
package uart_rx_controller_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int UART_WORD_SIZE = 8;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Serial line in, received-word handshake out, towards the downstream receiver buffer.
// The master modport is the receive controller itself; slave is the line/buffer side.
interface uart_rx_controller_if
    import uart_rx_controller_pkg::*;
#(
    parameter int WORD_SIZE = UART_WORD_SIZE
);
    logic                 RxD;
    logic                 Flag;
    logic [WORD_SIZE-1:0] DataOut;
    logic                 SetFlag;
    logic                 FramingError;
    logic                 OverrunError;
    logic                 Busy;

    modport master (
        input  RxD, Flag,
        output DataOut, SetFlag, FramingError, OverrunError, Busy
    );

    modport slave (
        output RxD, Flag,
        input  DataOut, SetFlag, FramingError, OverrunError, Busy
    );
endinterface

// File: rtl/uart_rx_controller_baud_tick.sv
// Oversample prescaler: one-cycle Tick every CLK_DIV clocks while enabled.
// Held at zero when disabled so the first tick lands CLK_DIV cycles after enable rises.
module uart_baud_tick
    import uart_rx_controller_pkg::*;
#(
    parameter int CLK_DIV = 27
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic Enable,
    output logic Tick
);
    localparam int            CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge Clock) begin
        if (!ResetN || !Enable) begin
            r_count <= '0;
        end else if (r_count == TERM) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign Tick = Enable && (r_count == TERM);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive front end: synchronise RxD, find the start edge, sample each bit at
// its midpoint, assemble an LSB-first word, check the stop bit and pulse the result.
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int WORD_SIZE  = UART_WORD_SIZE,
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    uart_rx_controller_if.master  bus
);
    localparam int            TW        = cnt_width(OVERSAMPLE);
    localparam int            BW        = cnt_width(WORD_SIZE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [WORD_SIZE-1:0]   r_shift;
    logic [WORD_SIZE-1:0]   r_data_out;
    logic                   r_set_flag;
    logic                   r_framing_err;
    logic                   r_overrun_err;
    logic                   w_tick;
    logic                   w_enable;
    logic                   w_tick_wrap;
    logic                   w_shift_en;
    logic                   w_accept;
    logic                   w_frame_err;

    assign w_enable = (r_state != RX_IDLE);

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
        .Clock  (Clock),
        .ResetN (ResetN),
        .Enable (w_enable),
        .Tick   (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_tick_wrap  = 1'b0;
        w_shift_en   = 1'b0;
        w_accept     = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            // Only a genuine 1->0 transition starts a frame, so a held-low line stays idle.
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (w_tick && (r_tick_cnt == HALF_LAST)) begin
                    w_tick_wrap  = 1'b1;
                    w_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_tick && (r_tick_cnt == FULL_LAST)) begin
                    w_tick_wrap = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_tick && (r_tick_cnt == FULL_LAST)) begin
                    w_tick_wrap  = 1'b1;
                    w_accept     = r_rx_sync;
                    w_frame_err  = !r_rx_sync;
                    w_state_next = RX_IDLE;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state       <= RX_IDLE;
            r_rx_meta     <= 1'b1;
            r_rx_sync     <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_set_flag    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rx_meta     <= bus.RxD;
            r_rx_sync     <= r_rx_meta;
            r_rx_prev     <= r_rx_sync;
            r_set_flag    <= w_accept;
            r_framing_err <= w_frame_err;
            // Overrun is reported but never blocks the load; the buffer gets overwritten.
            r_overrun_err <= w_accept && bus.Flag;
            if (w_accept) begin
                r_data_out <= r_shift;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_sync, r_shift[WORD_SIZE-1:1]};
            end
            if (r_state == RX_IDLE) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else begin
                if (w_tick) begin
                    r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + TW'(1);
                end
                if (w_shift_en) begin
                    r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BW'(1);
                end
            end
        end
    end

    assign bus.DataOut      = r_data_out;
    assign bus.SetFlag      = r_set_flag;
    assign bus.FramingError = r_framing_err;
    assign bus.OverrunError = r_overrun_err;
    assign bus.Busy         = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller at CLK_DIV=4, OVERSAMPLE=16 (64 clocks per bit).
// A negedge monitor logs every output pulse; each scenario compares the log to expectations.
module tb_uart_rx_controller;
    localparam int BIT_CLK = 64;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;

    uart_rx_controller_if #(.WORD_SIZE(8)) bus ();

    uart_rx_controller #(
        .WORD_SIZE  (8),
        .CLK_DIV    (4),
        .OVERSAMPLE (16)
    ) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int set_cnt  = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int both_cnt = 0;
    int last_set_cycle = 0;
    logic [7:0] got_data_q[$];
    bit         got_ov_q[$];
    logic [7:0] exp_data;

    always @(posedge Clock) cycle <= cycle + 1;

    always @(negedge Clock) begin
        if (bus.SetFlag === 1'b1) begin
            set_cnt++;
            last_set_cycle = cycle;
            got_data_q.push_back(bus.DataOut);
            got_ov_q.push_back(bus.OverrunError === 1'b1);
        end
        if (bus.FramingError === 1'b1) fe_cnt++;
        if (bus.OverrunError === 1'b1) ov_cnt++;
        if (bus.SetFlag === 1'b1 && bus.FramingError === 1'b1) both_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.RxD = b;
        wait_clks(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        bus.RxD = 1'b1;
    endtask

    task automatic clear_log();
        got_data_q.delete();
        got_ov_q.delete();
    endtask

    task automatic test_reset();
        bus.RxD  = 1'b1;
        bus.Flag = 1'b0;
        ResetN   = 1'b0;
        wait_clks(3);
        checks++; if (bus.DataOut !== 8'h00) begin failures++; $display("FAIL reset_dataout got=%h exp=00", bus.DataOut); end
        checks++; if (bus.SetFlag !== 1'b0) begin failures++; $display("FAIL reset_setflag got=%b exp=0", bus.SetFlag); end
        checks++; if (bus.FramingError !== 1'b0 || bus.OverrunError !== 1'b0) begin failures++; $display("FAIL reset_errors got fe=%b ov=%b exp=0", bus.FramingError, bus.OverrunError); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        ResetN = 1'b1;
        wait_clks(10);
        checks++; if (bus.Busy !== 1'b0 || set_cnt != 0) begin failures++; $display("FAIL idle_after_reset got busy=%b set=%0d exp busy=0 set=0", bus.Busy, set_cnt); end
        exp_data = 8'h00;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int start_cycle;
        int fe0;
        clear_log();
        fe0 = fe_cnt;
        start_cycle = cycle;
        send_frame(8'hA5, 1'b1);
        wait_clks(5);
        checks++; if (got_data_q.size() != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", got_data_q.size()); end
        else begin
            checks++; if (got_data_q[0] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", got_data_q[0]); end
            checks++; if (last_set_cycle - start_cycle < 605 || last_set_cycle - start_cycle > 617) begin failures++; $display("FAIL basic_latency got=%0d exp=605..617", last_set_cycle - start_cycle); end
        end
        checks++; if (fe_cnt != fe0 || ov_cnt != 0) begin failures++; $display("FAIL basic_errors got fe=%0d ov=%0d exp=0", fe_cnt - fe0, ov_cnt); end
        $display("frame a5 latency=%0d", last_set_cycle - start_cycle);
        clear_log();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(5);
        checks++; if (got_data_q.size() != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", got_data_q.size()); end
        else begin
            checks++; if (got_data_q[0] !== 8'h00 || got_data_q[1] !== 8'hFF) begin failures++; $display("FAIL b2b_data got=%h,%h exp=00,ff", got_data_q[0], got_data_q[1]); end
        end
        checks++; if (bus.DataOut !== 8'hFF) begin failures++; $display("FAIL b2b_dataout got=%h exp=ff", bus.DataOut); end
        exp_data = 8'hFF;
        $display("frames 00 ff received");
    endtask

    task automatic test_glitch();
        int s0, f0;
        s0 = set_cnt; f0 = fe_cnt;
        bus.RxD = 1'b0;
        wait_clks(5);
        checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got=%b exp=1", bus.Busy); end
        wait_clks(5);
        bus.RxD = 1'b1;
        wait_clks(30);
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop got=%b exp=0", bus.Busy); end
        wait_clks(200);
        checks++; if (set_cnt != s0 || fe_cnt != f0) begin failures++; $display("FAIL glitch_no_pulse got set=%0d fe=%0d exp=0", set_cnt - s0, fe_cnt - f0); end
        $display("glitch rejected");
    endtask

    task automatic test_framing();
        int s0, f0;
        s0 = set_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        wait_clks(5);
        checks++; if (fe_cnt - f0 != 1 || set_cnt != s0) begin failures++; $display("FAIL framing_pulses got fe=%0d set=%0d exp fe=1 set=0", fe_cnt - f0, set_cnt - s0); end
        checks++; if (bus.DataOut !== exp_data) begin failures++; $display("FAIL framing_dataout got=%h exp=%h", bus.DataOut, exp_data); end
        $display("frame 3c framing error seen");
    endtask

    task automatic test_overrun();
        int o0;
        clear_log();
        o0 = ov_cnt;
        bus.Flag = 1'b1;
        send_frame(8'h5A, 1'b1);
        wait_clks(5);
        bus.Flag = 1'b0;
        checks++; if (got_data_q.size() != 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", got_data_q.size()); end
        else begin
            checks++; if (got_ov_q[0] !== 1'b1) begin failures++; $display("FAIL overrun_coincident got=%b exp=1", got_ov_q[0]); end
            checks++; if (got_data_q[0] !== 8'h5A) begin failures++; $display("FAIL overrun_data got=%h exp=5a", got_data_q[0]); end
        end
        checks++; if (ov_cnt - o0 != 1) begin failures++; $display("FAIL overrun_count got=%0d exp=1", ov_cnt - o0); end
        exp_data = 8'h5A;
        $display("frame 5a with overrun");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int s0, f0;
        d = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        bus.RxD = d[4];
        wait_clks(20);
        s0 = set_cnt; f0 = fe_cnt;
        ResetN = 1'b0;
        wait_clks(1);
        checks++; if (bus.DataOut !== 8'h00 || bus.Busy !== 1'b0 || bus.SetFlag !== 1'b0) begin failures++; $display("FAIL midreset_outputs got data=%h busy=%b set=%b exp 00/0/0", bus.DataOut, bus.Busy, bus.SetFlag); end
        wait_clks(1);
        ResetN = 1'b1;
        wait_clks(1);
        checks++; if (set_cnt != s0 || fe_cnt != f0) begin failures++; $display("FAIL midreset_no_pulse got set=%0d fe=%0d exp=0", set_cnt - s0, fe_cnt - f0); end
        wait_clks(BIT_CLK - 23);
        for (int i = 5; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        wait_clks(800);
        clear_log();
        send_frame(8'h81, 1'b1);
        wait_clks(5);
        checks++; if (got_data_q.size() != 1 || bus.DataOut !== 8'h81) begin failures++; $display("FAIL midreset_next_frame got n=%0d data=%h exp n=1 data=81", got_data_q.size(), bus.DataOut); end
        exp_data = 8'h81;
        $display("frame 81 after mid-frame reset");
    endtask

    task automatic test_break();
        int s0, f0;
        s0 = set_cnt; f0 = fe_cnt;
        bus.RxD = 1'b0;
        wait_clks(2000);
        bus.RxD = 1'b1;
        wait_clks(100);
        checks++; if (fe_cnt - f0 != 1 || set_cnt != s0) begin failures++; $display("FAIL break_pulses got fe=%0d set=%0d exp fe=1 set=0", fe_cnt - f0, set_cnt - s0); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL break_busy got=%b exp=0", bus.Busy); end
        clear_log();
        send_frame(8'h55, 1'b1);
        wait_clks(5);
        checks++; if (got_data_q.size() != 1 || bus.DataOut !== 8'h55) begin failures++; $display("FAIL break_next_frame got n=%0d data=%h exp n=1 data=55", got_data_q.size(), bus.DataOut); end
        exp_data = 8'h55;
        $display("break then frame 55");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic stop, flag;
        int s0, f0;
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            flag = 1'($urandom_range(0, 1));
            clear_log();
            s0 = set_cnt; f0 = fe_cnt;
            bus.Flag = flag;
            send_frame(d, stop);
            wait_clks(3 + $urandom_range(0, 20));
            bus.Flag = 1'b0;
            if (stop) exp_data = d;
            checks++;
            if ((set_cnt - s0) != (stop ? 1 : 0) || (fe_cnt - f0) != (stop ? 0 : 1)) begin
                failures++;
                $display("FAIL rand_pulses got set=%0d fe=%0d exp set=%0d fe=%0d", set_cnt - s0, fe_cnt - f0, stop ? 1 : 0, stop ? 0 : 1);
            end
            checks++; if (bus.DataOut !== exp_data) begin failures++; $display("FAIL rand_data got=%h exp=%h", bus.DataOut, exp_data); end
            if (stop && got_ov_q.size() == 1) begin
                checks++; if (got_ov_q[0] !== flag) begin failures++; $display("FAIL rand_overrun got=%b exp=%b", got_ov_q[0], flag); end
            end
            $display("rand frame %0d data=%h stop=%b flag=%b dataout=%h", n, d, stop, flag, bus.DataOut);
        end
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_break();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
